// File: rtl/count_monitor.sv
// count_monitor: watches a 10-bit counter output and queues wrap-up, wrap-down
// and compare-match events with a 16-bit cycle timestamp in a 4-deep FIFO.
// Events that do not fit are dropped and tallied in a sticky flag and a
// saturating 8-bit counter.
module count_monitor (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  io_count,
  input  logic [9:0]  io_limit,
  input  logic [9:0]  io_cmp,
  input  logic        io_clr,
  output logic        io_evt_valid,
  input  logic        io_evt_ready,
  output logic [18:0] io_evt_bits,
  output logic        io_overflow,
  output logic [7:0]  io_drops,
  output logic [2:0]  io_level
);

  logic [9:0]  r_prev;
  logic        r_hv;
  logic [15:0] r_ts;
  logic [18:0] r_mem [0:3];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_level;
  logic        r_overflow;
  logic [7:0]  r_drops;

  logic w_change;
  logic w_wrap_up;
  logic w_wrap_dn;
  logic w_match;
  logic w_event;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Event detection against the previous sample, plus FIFO push/pop/drop decisions.
  always_comb begin
    w_change  = r_hv && (io_count != r_prev);
    w_wrap_up = w_change && (io_count == 10'd0) &&
                ((r_prev == io_limit) || (r_prev == 10'd1023));
    w_wrap_dn = w_change && (r_prev == 10'd0) && (io_count == 10'd1023);
    // First sample after reset/clear can match even without a change.
    w_match   = (io_count == io_cmp) && (w_change || !r_hv);
    w_event   = w_wrap_up || w_wrap_dn || w_match;
    w_pop     = (r_level != 3'd0) && io_evt_ready;
    // A clear discards any event seen in the same cycle without counting it as a drop.
    w_push    = w_event && !io_clr && ((r_level != 3'd4) || w_pop);
    w_drop    = w_event && !io_clr && !w_push;
  end

  // Sample history and free-running timestamp.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev <= 10'd0;
      r_hv   <= 1'b0;
      r_ts   <= 16'd0;
    end else begin
      r_prev <= io_count;
      if (io_clr) begin
        r_hv <= 1'b0;
        r_ts <= 16'd0;
      end else begin
        r_hv <= 1'b1;
        r_ts <= r_ts + 16'd1;
      end
    end
  end

  // FIFO pointers, occupancy and overflow bookkeeping.
  always_ff @(posedge clock) begin
    if (reset || io_clr) begin
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_level    <= 3'd0;
      r_overflow <= 1'b0;
      r_drops    <= 8'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      r_level <= r_level + {2'b00, w_push} - {2'b00, w_pop};
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != 8'hFF) r_drops <= r_drops + 8'd1;
      end
    end
  end

  // Entry storage; contents are only visible through a valid head, so no reset needed.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= {w_match, w_wrap_dn, w_wrap_up, r_ts};
  end

  assign io_evt_valid = (r_level != 3'd0);
  assign io_evt_bits  = io_evt_valid ? r_mem[r_rptr] : 19'd0;
  assign io_overflow  = r_overflow;
  assign io_drops     = r_drops;
  assign io_level     = r_level;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor with an expected-entry scoreboard queue.
module tb_count_monitor;

  logic        clock;
  logic        reset;
  logic [9:0]  io_count;
  logic [9:0]  io_limit;
  logic [9:0]  io_cmp;
  logic        io_clr;
  logic        io_evt_valid;
  logic        io_evt_ready;
  logic [18:0] io_evt_bits;
  logic        io_overflow;
  logic [7:0]  io_drops;
  logic [2:0]  io_level;

  int checks;
  int failures;
  logic [15:0] tb_ts;
  logic [18:0] sb [$];

  count_monitor dut (
    .clock        (clock),
    .reset        (reset),
    .io_count     (io_count),
    .io_limit     (io_limit),
    .io_cmp       (io_cmp),
    .io_clr       (io_clr),
    .io_evt_valid (io_evt_valid),
    .io_evt_ready (io_evt_ready),
    .io_evt_bits  (io_evt_bits),
    .io_overflow  (io_overflow),
    .io_drops     (io_drops),
    .io_level     (io_level)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs driven at negedge are captured at the posedge; tb_ts tracks
  // the timestamp the DUT holds during the cycle that follows.
  task automatic tick();
    @(posedge clock);
    if (reset || io_clr) tb_ts = 16'd0;
    else                 tb_ts = tb_ts + 16'd1;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    io_clr       = 1'b0;
    io_evt_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic push_match();
    sb.push_back({3'b100, tb_ts});
  endtask

  // n match events on distinct counts; only the first `keep` fit in the FIFO.
  task automatic make_events(input int n, input int base, input int keep);
    for (int i = 0; i < n; i++) begin
      io_count = 10'(base + i);
      io_cmp   = 10'(base + i);
      if (i < keep) push_match();
      tick();
    end
  endtask

  task automatic drain_all(input string tag);
    logic [18:0] exp_bits;
    io_evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (!io_evt_valid) break;
      if (sb.size() == 0) begin
        check({tag, "_extra"}, 32'(io_evt_bits), 32'h7FFFF);
      end else begin
        exp_bits = sb.pop_front();
        check({tag, "_bits"}, 32'(io_evt_bits), 32'(exp_bits));
      end
      tick();
    end
    io_evt_ready = 1'b0;
    check({tag, "_left"}, 32'(sb.size()), 32'd0);
    check({tag, "_level0"}, 32'(io_level), 32'd0);
  endtask

  initial begin
    logic [18:0] exp_bits;
    checks       = 0;
    failures     = 0;
    tb_ts        = 16'd0;
    reset        = 1'b1;
    io_clr       = 1'b0;
    io_evt_ready = 1'b0;
    io_count     = 10'd0;
    io_limit     = 10'd5;
    io_cmp       = 10'd1000;
    @(negedge clock);
    do_reset();

    // Reset state
    check("rst_valid", 32'(io_evt_valid), 32'd0);
    check("rst_bits", 32'(io_evt_bits), 32'd0);
    check("rst_ovf", 32'(io_overflow), 32'd0);
    check("rst_drops", 32'(io_drops), 32'd0);
    check("rst_level", 32'(io_level), 32'd0);

    // Modulo wrap at limit 5
    for (int k = 1; k <= 5; k++) begin
      tick();
      io_count = 10'(k);
    end
    tick();
    io_count = 10'd0;
    sb.push_back({3'b001, tb_ts});
    check("wrap_ts6", 32'(tb_ts), 32'd6);
    tick();
    check("wrap_valid", 32'(io_evt_valid), 32'd1);
    check("wrap_level", 32'(io_level), 32'd1);
    drain_all("wrap");

    // Down wrap coinciding with a match
    io_cmp   = 10'd1023;
    io_count = 10'd1;
    tick();
    io_count = 10'd0;
    tick();
    io_count = 10'd1023;
    sb.push_back({3'b110, tb_ts});
    tick();
    check("dn_level", 32'(io_level), 32'd1);
    drain_all("dn");

    // Held count: one match from the first sample only
    io_count = 10'd7;
    io_cmp   = 10'd7;
    do_reset();
    push_match();
    repeat (10) tick();
    check("hold_level", 32'(io_level), 32'd1);
    drain_all("hold");

    // Overflow: 6 events into a stalled FIFO
    make_events(6, 100, 4);
    check("ovf_level", 32'(io_level), 32'd4);
    check("ovf_flag", 32'(io_overflow), 32'd1);
    check("ovf_drops", 32'(io_drops), 32'd2);
    check("ovf_stable0", 32'(io_evt_bits), 32'(sb[0]));
    tick();
    check("ovf_stable1", 32'(io_evt_bits), 32'(sb[0]));
    drain_all("ovf");
    check("ovf_sticky", 32'(io_overflow), 32'd1);

    // Full FIFO with a pop and a push in the same cycle
    make_events(4, 200, 4);
    check("fp_level_pre", 32'(io_level), 32'd4);
    io_evt_ready = 1'b1;
    exp_bits = sb.pop_front();
    check("fp_head", 32'(io_evt_bits), 32'(exp_bits));
    io_count = 10'd204;
    io_cmp   = 10'd204;
    push_match();
    tick();
    io_evt_ready = 1'b0;
    check("fp_level", 32'(io_level), 32'd4);
    check("fp_drops", 32'(io_drops), 32'd2);
    drain_all("fp");

    // Soft clear mid-stream with an event in the clear cycle
    io_count = 10'd0;
    io_cmp   = 10'd1000;
    do_reset();
    make_events(13, 300, 4);
    io_evt_ready = 1'b1;
    exp_bits = sb.pop_front();
    check("clr_pre_head", 32'(io_evt_bits), 32'(exp_bits));
    tick();
    io_evt_ready = 1'b0;
    check("clr_pre_level", 32'(io_level), 32'd3);
    check("clr_pre_drops", 32'(io_drops), 32'd9);
    io_clr   = 1'b1;
    io_count = 10'd400;
    io_cmp   = 10'd400;
    tick();
    io_clr = 1'b0;
    sb.delete();
    check("clr_level", 32'(io_level), 32'd0);
    check("clr_ovf", 32'(io_overflow), 32'd0);
    check("clr_drops", 32'(io_drops), 32'd0);
    check("clr_valid", 32'(io_evt_valid), 32'd0);
    push_match();
    check("clr_ts0", 32'(tb_ts), 32'd0);
    tick();
    drain_all("clr");

    // Same sequence, interrupted by reset instead of clear
    io_count = 10'd0;
    io_cmp   = 10'd1000;
    do_reset();
    make_events(13, 300, 4);
    io_evt_ready = 1'b1;
    exp_bits = sb.pop_front();
    check("rs_pre_head", 32'(io_evt_bits), 32'(exp_bits));
    tick();
    io_evt_ready = 1'b0;
    check("rs_pre_drops", 32'(io_drops), 32'd9);
    reset    = 1'b1;
    io_clr   = 1'b1;
    io_count = 10'd400;
    io_cmp   = 10'd400;
    tick();
    reset  = 1'b0;
    io_clr = 1'b0;
    sb.delete();
    check("rs_level", 32'(io_level), 32'd0);
    check("rs_ovf", 32'(io_overflow), 32'd0);
    check("rs_drops", 32'(io_drops), 32'd0);
    push_match();
    tick();
    drain_all("rs");

    // Drop counter saturates at 255
    make_events(262, 500, 4);
    check("sat_drops", 32'(io_drops), 32'd255);
    check("sat_level", 32'(io_level), 32'd4);
    drain_all("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
